// File: rtl/count_pulse_gen_if.sv
// count_pulse_gen_if: control/status bundle between a delay/strobe controller
// and count_pulse_gen.
//   cnt    - delay count loaded on lden (WIDTH bits)
//   pw     - pulse width in cycles, 0 behaves as 1 (PW_WIDTH bits)
//   mode   - 0 one-shot, 1 periodic (sampled with lden)
//   lden   - load/start strobe
//   stop   - synchronous abort
//   pulse  - registered output pulse
//   busy   - generator is counting or pulsing
//   done   - one-cycle strobe at one-shot completion
//   remain - current delay down-counter value
// Modports: master = controller side, slave = generator side.
interface count_pulse_gen_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PW_WIDTH = 4
);
  logic [WIDTH-1:0]    cnt;
  logic [PW_WIDTH-1:0] pw;
  logic                mode;
  logic                lden;
  logic                stop;
  logic                pulse;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    remain;

  modport master (
    output cnt, pw, mode, lden, stop,
    input  pulse, busy, done, remain
  );

  modport slave (
    input  cnt, pw, mode, lden, stop,
    output pulse, busy, done, remain
  );
endinterface

// File: rtl/count_pulse_gen.sv
// count_pulse_gen: loadable delay/strobe generator.
// A load (lden) latches cnt/pw/mode into shadow registers, counts cnt cycles
// down, then drives pulse high for max(pw,1) cycles. One-shot mode finishes
// with a one-cycle done strobe; periodic mode repeats low-cnt/high-pw until
// stop, rst or a new load. Priority per edge: rst > stop > lden > sequencing.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - count_pulse_gen_if slave modport (cnt, pw, mode, lden, stop in;
//          pulse, busy, done, remain out, all registered)
module count_pulse_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PW_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  count_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PULSE = 2'd2
  } state_t;

  state_t              state;

  // Shadow copies of the load-time configuration.
  logic [WIDTH-1:0]    cnt_r;
  logic [PW_WIDTH-1:0] w_r;
  logic                mode_r;

  // Working counters and registered outputs.
  logic [WIDTH-1:0]    remain_r;
  logic [PW_WIDTH-1:0] wcnt;
  logic                pulse_r;
  logic                busy_r;
  logic                done_r;

  // Effective width of the incoming load: a zero width still gives one cycle.
  logic [PW_WIDTH-1:0] pw_eff;

  always_comb begin
    pw_eff = bus.pw;
    if (bus.pw == '0) begin
      pw_eff = PW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_r    <= '0;
      w_r      <= '0;
      mode_r   <= 1'b0;
      remain_r <= '0;
      wcnt     <= '0;
      pulse_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      // done is a strobe; only the one-shot completion branch raises it.
      done_r <= 1'b0;

      if (bus.stop) begin
        // Abort leaves the shadow registers untouched.
        state    <= IDLE;
        remain_r <= '0;
        wcnt     <= '0;
        pulse_r  <= 1'b0;
        busy_r   <= 1'b0;
      end else if (bus.lden) begin
        cnt_r  <= bus.cnt;
        w_r    <= pw_eff;
        mode_r <= bus.mode;
        busy_r <= 1'b1;
        if (bus.cnt == '0) begin
          // Zero delay: the pulse starts on the load edge itself, using the
          // incoming width since w_r is only being written this cycle.
          state    <= PULSE;
          remain_r <= '0;
          wcnt     <= pw_eff;
          pulse_r  <= 1'b1;
        end else begin
          state    <= COUNT;
          remain_r <= bus.cnt;
          wcnt     <= '0;
          pulse_r  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            remain_r <= '0;
            pulse_r  <= 1'b0;
            busy_r   <= 1'b0;
          end

          COUNT: begin
            // remain holds at 1 on the final count cycle rather than
            // reaching 0; the transition to PULSE happens from 1.
            if (remain_r <= WIDTH'(1)) begin
              state    <= PULSE;
              remain_r <= '0;
              wcnt     <= w_r;
              pulse_r  <= 1'b1;
            end else begin
              remain_r <= remain_r - WIDTH'(1);
            end
          end

          PULSE: begin
            if (wcnt <= PW_WIDTH'(1)) begin
              if (!mode_r) begin
                state   <= IDLE;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                wcnt    <= '0;
              end else if (cnt_r != '0) begin
                state    <= COUNT;
                pulse_r  <= 1'b0;
                remain_r <= cnt_r;
                wcnt     <= '0;
              end else begin
                // Periodic with zero delay: pulse stays high, width reloads.
                wcnt <= w_r;
              end
            end else begin
              wcnt <= wcnt - PW_WIDTH'(1);
            end
          end

          default: begin
            state    <= IDLE;
            remain_r <= '0;
            wcnt     <= '0;
            pulse_r  <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pulse  = pulse_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.remain = remain_r;

endmodule

// File: tb/tb_count_pulse_gen.sv
module tb_count_pulse_gen;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  count_pulse_gen_if #(.WIDTH(8),  .PW_WIDTH(4)) bus8 ();
  count_pulse_gen_if #(.WIDTH(16), .PW_WIDTH(4)) bus16 ();

  count_pulse_gen #(.WIDTH(8), .PW_WIDTH(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  count_pulse_gen #(.WIDTH(16), .PW_WIDTH(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] c, input logic [3:0] w, input logic m);
    bus8.cnt  = c;
    bus8.pw   = w;
    bus8.mode = m;
    bus8.lden = 1'b1;
    tick();
    bus8.lden = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000 || bus8.remain !== 8'd0) begin
      fails++;
      $display("FAIL reset8: got p/b/d=%b%b%b remain=%0d want 000 remain=0",
               bus8.pulse, bus8.busy, bus8.done, bus8.remain);
    end
    tests++;
    if ({bus16.pulse, bus16.busy, bus16.done} !== 3'b000 || bus16.remain !== 16'd0) begin
      fails++;
      $display("FAIL reset16: got p/b/d=%b%b%b remain=%0d want 000 remain=0",
               bus16.pulse, bus16.busy, bus16.done, bus16.remain);
    end
    rst = 1'b0;
    tick();
  endtask

  // cnt=9, pw=0, one-shot: pulse high for exactly one cycle after edge k+9.
  task automatic test_oneshot();
    load8(8'd9, 4'd0, 1'b0);
    for (int j = 0; j <= 11; j++) begin
      if (j > 0) tick();
      tests++;
      if (bus8.pulse !== (j == 9)) begin
        fails++;
        $display("FAIL oneshot_pulse k+%0d: got %b want %b", j, bus8.pulse, (j == 9));
      end
      tests++;
      if (bus8.done !== (j == 10)) begin
        fails++;
        $display("FAIL oneshot_done k+%0d: got %b want %b", j, bus8.done, (j == 10));
      end
      tests++;
      if (bus8.busy !== (j <= 9)) begin
        fails++;
        $display("FAIL oneshot_busy k+%0d: got %b want %b", j, bus8.busy, (j <= 9));
      end
      if (j <= 8) begin
        tests++;
        if (bus8.remain !== 8'(9 - j)) begin
          fails++;
          $display("FAIL oneshot_remain k+%0d: got %0d want %0d", j, bus8.remain, 9 - j);
        end
      end
      if (j >= 10) begin
        tests++;
        if (bus8.remain !== 8'd0) begin
          fails++;
          $display("FAIL oneshot_remain_idle k+%0d: got %0d want 0", j, bus8.remain);
        end
      end
    end
  endtask

  // cnt=3, pw=2, periodic: low 3 / high 2, then stop while pulse is high.
  task automatic test_periodic();
    logic exp;
    load8(8'd3, 4'd2, 1'b1);
    for (int j = 1; j <= 23; j++) begin
      tick();
      exp = ((j % 5) == 3) || ((j % 5) == 4);
      tests++;
      if (bus8.pulse !== exp || bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
        fails++;
        $display("FAIL periodic k+%0d: got p/d/b=%b%b%b want %b01",
                 j, bus8.pulse, bus8.done, bus8.busy, exp);
      end
    end
    bus8.stop = 1'b1;
    tick();
    bus8.stop = 1'b0;
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000 || bus8.remain !== 8'd0) begin
      fails++;
      $display("FAIL stop_mid_pulse: got p/b/d=%b%b%b remain=%0d want 000 remain=0",
               bus8.pulse, bus8.busy, bus8.done, bus8.remain);
    end
    tick();
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000) begin
      fails++;
      $display("FAIL stop_mid_pulse_after: got p/b/d=%b%b%b want 000",
               bus8.pulse, bus8.busy, bus8.done);
    end
  endtask

  task automatic test_zero_count();
    // One-shot cnt=0 pw=4: high from the load edge for 4 cycles, then done.
    load8(8'd0, 4'd4, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) tick();
      tests++;
      if (bus8.pulse !== (j <= 3) || bus8.done !== (j == 4) || bus8.busy !== (j <= 3)) begin
        fails++;
        $display("FAIL zero_oneshot k+%0d: got p/d/b=%b%b%b want %b%b%b", j,
                 bus8.pulse, bus8.done, bus8.busy, (j <= 3), (j == 4), (j <= 3));
      end
    end
    // Periodic cnt=0: pulse constantly high until stop.
    load8(8'd0, 4'd3, 1'b1);
    for (int j = 0; j < 15; j++) begin
      if (j > 0) tick();
      tests++;
      if (bus8.pulse !== 1'b1 || bus8.done !== 1'b0) begin
        fails++;
        $display("FAIL zero_periodic k+%0d: got p/d=%b%b want 10", j, bus8.pulse, bus8.done);
      end
    end
    bus8.stop = 1'b1;
    tick();
    bus8.stop = 1'b0;
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000) begin
      fails++;
      $display("FAIL zero_periodic_stop: got p/b/d=%b%b%b want 000",
               bus8.pulse, bus8.busy, bus8.done);
    end
  endtask

  task automatic test_stop();
    int dcnt;
    dcnt = 0;
    load8(8'd9, 4'd1, 1'b0);
    tick();
    tick();
    tick();
    bus8.stop = 1'b1;
    tick();
    bus8.stop = 1'b0;
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000 || bus8.remain !== 8'd0) begin
      fails++;
      $display("FAIL stop_mid_count: got p/b/d=%b%b%b remain=%0d want 000 remain=0",
               bus8.pulse, bus8.busy, bus8.done, bus8.remain);
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.pulse === 1'b1) dcnt++;
    end
    tests++;
    if (dcnt !== 0) begin
      fails++;
      $display("FAIL stop_mid_count_quiet: got %0d active cycles want 0", dcnt);
    end
    // lden together with stop: stop wins, generator stays idle.
    bus8.stop = 1'b1;
    load8(8'd4, 4'd1, 1'b0);
    bus8.stop = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 7; j++) begin
      if (bus8.busy !== 1'b0 || bus8.pulse !== 1'b0 || bus8.remain !== 8'd0) dcnt++;
      tick();
    end
    tests++;
    if (dcnt !== 0) begin
      fails++;
      $display("FAIL lden_stop_same_cycle: got %0d non-idle cycles want 0", dcnt);
    end
  endtask

  // cnt=9 pw=3 one-shot, reloaded with cnt=5 pw=2 during its pulse.
  task automatic test_back_to_back();
    int dcnt;
    dcnt = 0;
    load8(8'd9, 4'd3, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (bus8.done === 1'b1) dcnt++;
    end
    tests++;
    if (bus8.pulse !== 1'b1) begin
      fails++;
      $display("FAIL restart_first_pulse: got %b want 1", bus8.pulse);
    end
    load8(8'd5, 4'd2, 1'b0);
    tests++;
    if (bus8.pulse !== 1'b0 || bus8.remain !== 8'd5 || bus8.busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_load: got p=%b remain=%0d busy=%b want p=0 remain=5 busy=1",
               bus8.pulse, bus8.remain, bus8.busy);
    end
    if (bus8.done === 1'b1) dcnt++;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (bus8.done === 1'b1) dcnt++;
      tests++;
      if (bus8.pulse !== (j == 5 || j == 6) || bus8.done !== (j == 7)) begin
        fails++;
        $display("FAIL restart m+%0d: got p/d=%b%b want %b%b", j,
                 bus8.pulse, bus8.done, (j == 5 || j == 6), (j == 7));
      end
    end
    tests++;
    if (dcnt !== 1) begin
      fails++;
      $display("FAIL restart_done_count: got %0d want 1", dcnt);
    end
  endtask

  task automatic test_reset_mid_periodic();
    load8(8'd2, 4'd2, 1'b1);
    for (int j = 1; j <= 6; j++) tick();
    tests++;
    if (bus8.pulse !== 1'b1) begin
      fails++;
      $display("FAIL rst_periodic_pre: got %b want 1", bus8.pulse);
    end
    rst       = 1'b1;
    bus8.cnt  = 8'd1;
    bus8.lden = 1'b1;
    tick();
    tests++;
    if ({bus8.pulse, bus8.busy, bus8.done} !== 3'b000 || bus8.remain !== 8'd0) begin
      fails++;
      $display("FAIL rst_mid_periodic: got p/b/d=%b%b%b remain=%0d want 000 remain=0",
               bus8.pulse, bus8.busy, bus8.done, bus8.remain);
    end
    rst       = 1'b0;
    bus8.lden = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    tests++;
    if (bus8.pulse !== 1'b0 || bus8.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_lden_ignored: got p/b=%b%b want 00", bus8.pulse, bus8.busy);
    end
  endtask

  task automatic test_wide();
    bus16.cnt  = 16'd300;
    bus16.pw   = 4'd1;
    bus16.mode = 1'b0;
    bus16.lden = 1'b1;
    tick();
    bus16.lden = 1'b0;
    tests++;
    if (bus16.remain !== 16'd300 || bus16.busy !== 1'b1) begin
      fails++;
      $display("FAIL wide_load: got remain=%0d busy=%b want 300 1", bus16.remain, bus16.busy);
    end
    for (int j = 1; j <= 299; j++) tick();
    tests++;
    if (bus16.pulse !== 1'b0 || bus16.remain !== 16'd1) begin
      fails++;
      $display("FAIL wide_k299: got p=%b remain=%0d want 0 1", bus16.pulse, bus16.remain);
    end
    tick();
    tests++;
    if (bus16.pulse !== 1'b1) begin
      fails++;
      $display("FAIL wide_k300: got p=%b want 1", bus16.pulse);
    end
    tick();
    tests++;
    if (bus16.pulse !== 1'b0 || bus16.done !== 1'b1 || bus16.busy !== 1'b0) begin
      fails++;
      $display("FAIL wide_k301: got p/d/b=%b%b%b want 010", bus16.pulse, bus16.done, bus16.busy);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    bus8.cnt   = '0;
    bus8.pw    = '0;
    bus8.mode  = 1'b0;
    bus8.lden  = 1'b0;
    bus8.stop  = 1'b0;
    bus16.cnt  = '0;
    bus16.pw   = '0;
    bus16.mode = 1'b0;
    bus16.lden = 1'b0;
    bus16.stop = 1'b0;

    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_count();
    test_stop();
    test_back_to_back();
    test_reset_mid_periodic();
    test_wide();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_pulse_gen.md
# count_pulse_gen

Parametrised successor to the single-shot count/pulse block. Loads a delay count, counts down, and emits an output pulse of programmable width. It runs in one-shot or periodic mode, supports abort, and reports busy/done status. It sits beside the system timers as a general delay/strobe generator driven by a controller that loads `cnt` with `lden`.

## Interface
- `WIDTH`, 8: width of delay count `cnt` and internal down-counter.
- `PW_WIDTH`, 4: width of pulse-width input `pw`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cnt`  in  WIDTH  delay in cycles from load (or pulse end) to pulse rise.
- `pw`  in  PW_WIDTH  pulse width in cycles; 0 treated as 1.
- `mode`  in  1  0 = one-shot, 1 = periodic; sampled with `lden`.
- `lden`  in  1  load/start strobe; samples `cnt`, `pw`, `mode`.
- `stop`  in  1  synchronous abort.
- `pulse`  out  1  registered output pulse.
- `busy`  out  1  high in COUNT or PULSE.
- `done`  out  1  one-cycle strobe at one-shot completion.
- `remain`  out  WIDTH  current down-counter value; 0 when IDLE.

## Operation
- States: IDLE, COUNT, PULSE. Shadow registers `cnt_r`, `w_r = max(pw,1)`, `mode_r` are written only on `lden`.
- Priority at each edge: `rst` > `stop` > `lden` > normal sequencing.
- `rst`: state IDLE; `pulse`=0, `busy`=0, `done`=0, `remain`=0, shadows cleared.
- `stop`: state IDLE, `pulse`=0, `remain`=0, no `done`. Shadows keep their values.
- `lden`, accepted in any state (restart):
  - Latch the shadows.
  - If `cnt`=0, go to PULSE; `pulse` rises on this edge.
  - Otherwise go to COUNT with `remain`=`cnt`.
- COUNT:
  - If `remain`=1, go to PULSE and set `pulse`=1, width counter=`w_r`.
  - Otherwise `remain` decrements.
- PULSE: width counter decrements. When it is 1:
  - One-shot: go to IDLE, `pulse`=0, `done`=1 for one cycle.
  - Periodic with `cnt_r`≠0: go to COUNT, `pulse`=0, `remain`=`cnt_r`.
  - Periodic with `cnt_r`=0: stay in PULSE, reload width, `pulse` stays 1 continuously.
- Arithmetic is unsigned with no wrap. `remain` never decrements below 1 in COUNT.
- `busy` = (state≠IDLE), registered consistently with state.

## Timing
- Load edge k with `cnt`=N≥1: `pulse` rises at edge k+N, high for W=max(`pw`,1) cycles, falls at edge k+N+W.
- Load with `cnt`=0: `pulse` high from edge k.
- One-shot: `done` high for the cycle after edge k+N+W; `busy` falls at the same edge.
- Periodic: period = N+W cycles; low phase N, high phase W; continues until `stop`, `rst` or a new `lden`.
- `lden` during PULSE: `pulse` drops (if new `cnt`≠0) at that edge and the new sequence starts. The prior one-shot does not generate `done`.
- `lden` and `stop` in the same cycle: `stop` wins, shadows are not updated.
- `lden` and `rst` in the same cycle: reset wins.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `lden` with `cnt`=9, `pw`=0, `mode`=0 at edge k -> `pulse` high exactly cycle k+9 to k+10; `done` one cycle after; `busy` high k..k+9; `remain` counts 9→1.
- Periodic: `cnt`=3, `pw`=2, `mode`=1 -> `pulse` pattern low3/high2 repeating with period 5 for ≥4 periods; `done` never asserts.
- `cnt`=0 edge cases: one-shot `pw`=4 -> pulse high 4 cycles from load edge, then `done`. Periodic `cnt`=0 -> `pulse` constantly 1 until `stop`.
- `stop` mid-COUNT and mid-PULSE -> `pulse`=0, `busy`=0, `remain`=0 at next edge, no `done`. Simultaneous `lden`+`stop` -> stays IDLE.
- Restart: `lden` (`cnt`=5) during the pulse of a `cnt`=9 one-shot -> new pulse 5 cycles later, exactly one `done` total.
- `rst` asserted mid-periodic, and `WIDTH`=16 with `cnt`=300 -> all outputs 0 after reset edge; pulse rises at k+300.
